// File: rtl/oa_wb_scheduler.sv
// Write-back sequencing for the output-activation path: tracks tiles waiting in
// the OA FIFO, grants oa_writer access to the shared ICB port, throttles loaders.
module oa_wb_scheduler #(
   parameter int unsigned REG_WIDTH   = 32,
   parameter int unsigned MAX_PENDING = 4,
   parameter int unsigned HIGH_WATER  = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               init_cfg,
   input  logic [REG_WIDTH-1:0]               tile_count,
   input  logic                               tile_ready,
   input  logic                               write_oa_req,
   input  logic                               write_done,
   input  logic                               ld_bus_busy,
   output logic                               write_oa_granted,
   output logic                               oa_bus_lock,
   output logic                               ld_pause,
   output logic                               oa_calc_over,
   output logic [REG_WIDTH-1:0]               tiles_written,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending_tiles,
   output logic                               overflow_err,
   output logic                               proto_err
);

   localparam int unsigned PW = $clog2(MAX_PENDING + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_BUSY = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]           r_state;
   logic [REG_WIDTH-1:0] r_tile_count;
   logic [REG_WIDTH-1:0] r_tiles_written;
   logic [PW-1:0]        r_pending;
   logic                 r_granted;
   logic                 r_lock;
   logic                 r_calc_over;
   logic                 r_ovf;
   logic                 r_proto;

   logic [1:0]           w_state_nxt;
   logic [REG_WIDTH-1:0] w_tile_count_nxt;
   logic [REG_WIDTH-1:0] w_tiles_written_nxt;
   logic [REG_WIDTH-1:0] w_tiles_inc;
   logic [PW-1:0]        w_pending_nxt;
   logic                 w_granted_nxt;
   logic                 w_lock_nxt;
   logic                 w_calc_over_nxt;
   logic                 w_ovf_nxt;
   logic                 w_proto_nxt;
   logic                 w_grant;
   logic                 w_tile_in;
   logic                 w_at_max;
   logic                 w_req_blocked;

   // Grant decision and loader throttle use the sampled inputs of this cycle
   assign w_grant       = (r_state == S_WAIT) && write_oa_req && (r_pending != '0) && !ld_bus_busy;
   assign w_req_blocked = (r_state == S_WAIT) && write_oa_req && (r_pending != '0) && ld_bus_busy;
   assign w_tile_in     = tile_ready && (r_state != S_IDLE);
   assign w_at_max      = (r_pending == PW'(MAX_PENDING));
   assign w_tiles_inc   = r_tiles_written + REG_WIDTH'(1);
   assign ld_pause      = (r_pending >= PW'(HIGH_WATER)) || w_req_blocked;

   // Next-state and next-output logic; init_cfg overrides everything else
   always_comb begin
      w_state_nxt         = r_state;
      w_tile_count_nxt    = r_tile_count;
      w_tiles_written_nxt = r_tiles_written;
      w_pending_nxt       = r_pending;
      w_granted_nxt       = 1'b0;
      w_lock_nxt          = r_lock;
      w_calc_over_nxt     = r_calc_over;
      w_ovf_nxt           = r_ovf;
      w_proto_nxt         = r_proto;

      if (w_tile_in && !w_grant && !w_at_max) begin
         w_pending_nxt = r_pending + PW'(1);
      end else if (w_grant && !w_tile_in) begin
         w_pending_nxt = r_pending - PW'(1);
      end
      if (w_tile_in && w_at_max) begin
         w_ovf_nxt = 1'b1;
      end
      if (write_done && (r_state != S_BUSY)) begin
         w_proto_nxt = 1'b1;
      end

      case (r_state)
         S_WAIT: begin
            if (w_grant) begin
               w_state_nxt   = S_BUSY;
               w_granted_nxt = 1'b1;
               w_lock_nxt    = 1'b1;
            end
         end
         S_BUSY: begin
            if (write_done) begin
               w_tiles_written_nxt = w_tiles_inc;
               w_lock_nxt          = 1'b0;
               if (w_tiles_inc == r_tile_count) begin
                  w_state_nxt     = S_DONE;
                  w_calc_over_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         default: begin
         end
      endcase

      if (init_cfg) begin
         w_tile_count_nxt    = tile_count;
         w_tiles_written_nxt = '0;
         w_pending_nxt       = '0;
         w_granted_nxt       = 1'b0;
         w_lock_nxt          = 1'b0;
         w_ovf_nxt           = 1'b0;
         w_proto_nxt         = 1'b0;
         w_calc_over_nxt     = (tile_count == '0);
         w_state_nxt         = (tile_count == '0) ? S_DONE : S_WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_tile_count    <= '0;
         r_tiles_written <= '0;
         r_pending       <= '0;
         r_granted       <= 1'b0;
         r_lock          <= 1'b0;
         r_calc_over     <= 1'b0;
         r_ovf           <= 1'b0;
         r_proto         <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_tile_count    <= w_tile_count_nxt;
         r_tiles_written <= w_tiles_written_nxt;
         r_pending       <= w_pending_nxt;
         r_granted       <= w_granted_nxt;
         r_lock          <= w_lock_nxt;
         r_calc_over     <= w_calc_over_nxt;
         r_ovf           <= w_ovf_nxt;
         r_proto         <= w_proto_nxt;
      end
   end

   assign write_oa_granted = r_granted;
   assign oa_bus_lock      = r_lock;
   assign oa_calc_over     = r_calc_over;
   assign tiles_written    = r_tiles_written;
   assign pending_tiles    = r_pending;
   assign overflow_err     = r_ovf;
   assign proto_err        = r_proto;

endmodule

// File: tb/tb_oa_wb_scheduler.sv
// Bench for oa_wb_scheduler: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_oa_wb_scheduler;

   localparam int unsigned RW   = 32;
   localparam int unsigned MAXP = 4;
   localparam int unsigned HW   = 3;
   localparam int unsigned PW   = $clog2(MAXP + 1);

   localparam int P_IDLE = 0;
   localparam int P_WAIT = 1;
   localparam int P_BUSY = 2;
   localparam int P_DONE = 3;

   logic          clk;
   logic          rst;
   logic          init_cfg;
   logic [RW-1:0] tile_count;
   logic          tile_ready;
   logic          write_oa_req;
   logic          write_done;
   logic          ld_bus_busy;
   logic          write_oa_granted;
   logic          oa_bus_lock;
   logic          ld_pause;
   logic          oa_calc_over;
   logic [RW-1:0] tiles_written;
   logic [PW-1:0] pending_tiles;
   logic          overflow_err;
   logic          proto_err;

   oa_wb_scheduler #(.REG_WIDTH(RW), .MAX_PENDING(MAXP), .HIGH_WATER(HW)) dut (
      .clk(clk), .rst(rst), .init_cfg(init_cfg), .tile_count(tile_count),
      .tile_ready(tile_ready), .write_oa_req(write_oa_req), .write_done(write_done),
      .ld_bus_busy(ld_bus_busy), .write_oa_granted(write_oa_granted),
      .oa_bus_lock(oa_bus_lock), .ld_pause(ld_pause), .oa_calc_over(oa_calc_over),
      .tiles_written(tiles_written), .pending_tiles(pending_tiles),
      .overflow_err(overflow_err), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: phase of the write-back cycle plus plain counters
   int      m_phase;
   longint  m_tc;
   longint  m_tw;
   int      m_pend;
   bit      m_gr, m_lock, m_over, m_ovf, m_proto;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_grant();
      return (m_phase == P_WAIT) && write_oa_req && (m_pend > 0) && !ld_bus_busy;
   endfunction

   function automatic bit model_pause();
      return (m_pend >= int'(HW)) ||
             ((m_phase == P_WAIT) && write_oa_req && (m_pend > 0) && ld_bus_busy);
   endfunction

   task automatic model_step();
      bit g, tr;
      int p;
      if (rst) begin
         m_phase = P_IDLE; m_tc = 0; m_tw = 0; m_pend = 0;
         m_gr = 0; m_lock = 0; m_over = 0; m_ovf = 0; m_proto = 0;
      end else if (init_cfg) begin
         m_tc = longint'(tile_count); m_tw = 0; m_pend = 0;
         m_gr = 0; m_lock = 0; m_ovf = 0; m_proto = 0;
         m_over  = (m_tc == 0);
         m_phase = (m_tc == 0) ? P_DONE : P_WAIT;
      end else begin
         g  = model_grant();
         tr = tile_ready && (m_phase != P_IDLE);
         if (tr && m_pend == int'(MAXP)) m_ovf = 1;
         if (write_done && m_phase != P_BUSY) m_proto = 1;
         p = m_pend + (tr ? 1 : 0) - (g ? 1 : 0);
         m_pend = (p > int'(MAXP)) ? int'(MAXP) : p;
         m_gr = g;
         if (g) begin
            m_phase = P_BUSY;
            m_lock  = 1;
         end else if (m_phase == P_BUSY && write_done) begin
            m_tw++;
            m_lock = 0;
            if (m_tw == m_tc) begin
               m_phase = P_DONE;
               m_over  = 1;
            end else begin
               m_phase = P_WAIT;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("granted",       write_oa_granted, 64'(m_gr));
      chk("bus_lock",      oa_bus_lock,      64'(m_lock));
      chk("calc_over",     oa_calc_over,     64'(m_over));
      chk("tiles_written", tiles_written,    64'(m_tw));
      chk("pending_tiles", pending_tiles,    64'(m_pend));
      chk("overflow_err",  overflow_err,     64'(m_ovf));
      chk("proto_err",     proto_err,        64'(m_proto));
   endtask

   // One clock: inputs already set after a falling edge; pulses cleared afterwards
   task automatic tick();
      #1 chk("ld_pause", ld_pause, 64'(model_pause()));
      @(posedge clk);
      model_step();
      #1 check_outputs();
      @(negedge clk);
      tile_ready = 0; write_done = 0; init_cfg = 0;
   endtask

   task automatic do_init(input int tc);
      tile_count = RW'(tc);
      init_cfg   = 1;
      tick();
   endtask

   task automatic push_tiles(input int n);
      for (int k = 0; k < n; k++) begin
         tile_ready = 1;
         tick();
      end
   endtask

   initial begin
      rst = 1; init_cfg = 0; tile_count = '0; tile_ready = 0;
      write_oa_req = 0; write_done = 0; ld_bus_busy = 0;
      m_phase = P_IDLE; m_tc = 0; m_tw = 0; m_pend = 0;
      m_gr = 0; m_lock = 0; m_over = 0; m_ovf = 0; m_proto = 0;
      @(negedge clk);
      tick(); tick();
      rst = 0;
      chk("rst_over", oa_calc_over, 0);
      chk("rst_pend", pending_tiles, 0);
      tick();

      // Basic three-tile flow
      do_init(3);
      chk("basic_over0", oa_calc_over, 0);
      push_tiles(3);
      chk("basic_pend3", pending_tiles, 3);
      chk("basic_pause", ld_pause, 1);
      for (int i = 0; i < 3; i++) begin
         write_oa_req = 1; tick();
         chk("basic_grant", write_oa_granted, 1);
         chk("basic_lock", oa_bus_lock, 1);
         chk("basic_pend_dec", pending_tiles, 64'(2 - i));
         write_oa_req = 0; tick();
         chk("basic_grant_pulse", write_oa_granted, 0);
         write_done = 1; tick();
         chk("basic_unlock", oa_bus_lock, 0);
         chk("basic_tw", tiles_written, 64'(i + 1));
      end
      chk("basic_over", oa_calc_over, 1);

      // Zero tiles
      do_init(0);
      chk("zero_over", oa_calc_over, 1);
      tile_ready = 1; write_oa_req = 1; tick();
      chk("zero_nogrant", write_oa_granted, 0);
      write_oa_req = 0;

      // Bus contention
      do_init(1);
      push_tiles(1);
      write_oa_req = 1; ld_bus_busy = 1;
      #1 chk("cont_pause", ld_pause, 1);
      repeat (3) tick();
      chk("cont_nogrant", write_oa_granted, 0);
      ld_bus_busy = 0; tick();
      chk("cont_grant", write_oa_granted, 1);
      write_oa_req = 0; write_done = 1; tick();
      chk("cont_over", oa_calc_over, 1);

      // Credits and overflow
      do_init(5);
      for (int i = 1; i <= 5; i++) begin
         tile_ready = 1; tick();
         chk("cred_pause", ld_pause, 64'(i >= 3));
      end
      chk("cred_pend_sat", pending_tiles, 4);
      chk("cred_ovf", overflow_err, 1);
      do_init(2);
      chk("cred_ovf_clr", overflow_err, 0);
      push_tiles(2);
      write_oa_req = 1; tile_ready = 1; tick();
      chk("cred_coinc_grant", write_oa_granted, 1);
      chk("cred_coinc_pend", pending_tiles, 2);
      write_oa_req = 0;

      // Abort during BUSY, then a full run
      do_init(2);
      push_tiles(1);
      write_oa_req = 1; tick(); write_oa_req = 0;
      chk("abort_lock_pre", oa_bus_lock, 1);
      do_init(2);
      chk("abort_lock", oa_bus_lock, 0);
      chk("abort_tw", tiles_written, 0);
      chk("abort_pend", pending_tiles, 0);
      push_tiles(2);
      for (int i = 0; i < 2; i++) begin
         write_oa_req = 1; tick();
         chk("abort_run_grant", write_oa_granted, 1);
         write_oa_req = 0; write_done = 1; tick();
         tick();
      end
      chk("abort_run_over", oa_calc_over, 1);
      chk("abort_run_tw", tiles_written, 2);

      // Protocol error, then reset mid-BUSY
      do_init(2);
      push_tiles(1);
      write_oa_req = 1; tick(); write_oa_req = 0;
      write_done = 1; tick();
      write_done = 1; tick();
      chk("proto_err", proto_err, 1);
      chk("proto_tw", tiles_written, 1);
      push_tiles(1);
      write_oa_req = 1; tick(); write_oa_req = 0;
      rst = 1; tick(); rst = 0;
      chk("rst_lock", oa_bus_lock, 0);
      chk("rst_tw", tiles_written, 0);
      chk("rst_proto", proto_err, 0);
      tick();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst          = ($urandom_range(499) == 0);
         tile_count   = RW'($urandom_range(6));
         init_cfg     = !rst && (($urandom_range(199) == 0) ||
                        ((m_phase == P_IDLE || m_phase == P_DONE) && $urandom_range(9) == 0));
         write_oa_req = ($urandom_range(99) < 60);
         ld_bus_busy  = ($urandom_range(99) < 30);
         write_done   = (m_phase == P_BUSY) ? ($urandom_range(99) < 35)
                                            : ($urandom_range(99) == 0);
         tile_ready   = ($urandom_range(99) < 30);
         if (tile_ready && m_pend == int'(MAXP) && model_grant()) tile_ready = 0;
         tick();
         rst = 0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/oa_wb_scheduler.md
# oa_wb_scheduler

Sequencing controller for the output-activation write-back path. It sits between the systolic-array tile-completion signal, the `oa_writer` master, and the input/weight loaders that share the external ICB port. It counts finished tiles waiting in the OA FIFO and grants each `write_oa_req` only when a tile is pending and the loaders have released the bus. It throttles the loaders when write-back falls behind, and it reports completion of all `tile_count` tiles.

## Interface
Parameters:
- `REG_WIDTH`, 32: width of the tile-count configuration and counters.
- `MAX_PENDING`, 4: OA FIFO depth in tiles; pending-tile credit limit.
- `HIGH_WATER`, 3: pending-tile count at which loaders are asked to pause.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `init_cfg`  in  1  latch `tile_count` and restart; honoured in any state.
- `tile_count`  in  REG_WIDTH  total tiles for the layer.
- `tile_ready`  in  1  1-cycle pulse: one tile fully pushed into the OA FIFO.
- `write_oa_req`  in  1  level from `oa_writer`: requests the next write-back grant.
- `write_done`  in  1  1-cycle pulse from `oa_writer`: the current tile's write-back has finished.
- `ld_bus_busy`  in  1  loaders currently own the ICB port (mid-burst).
- `write_oa_granted`  out  1  1-cycle grant pulse to `oa_writer`.
- `oa_bus_lock`  out  1  ICB port reserved for `oa_writer`; loaders must not start a burst.
- `ld_pause`  out  1  request for loaders to stop at their next burst boundary.
- `oa_calc_over`  out  1  level: all tiles written.
- `tiles_written`  out  REG_WIDTH  completed write-backs since `init_cfg`.
- `pending_tiles`  out  $clog2(MAX_PENDING+1)  tiles waiting in the FIFO.
- `overflow_err`  out  1  sticky: `tile_ready` arrived while `pending_tiles`==MAX_PENDING.
- `proto_err`  out  1  sticky: `write_done` arrived outside BUSY.

## Operation
- **States:**
  - IDLE: after reset.
  - WAIT: waiting to grant.
  - BUSY: grant issued, write-back in flight.
  - DONE: layer complete.
- **IDLE → init_cfg:**
  - Latch `tile_count`; clear `tiles_written`, `pending_tiles` and both error flags.
  - `tile_count`==0 → DONE. Otherwise → WAIT.
- **WAIT → BUSY:** taken when `write_oa_req` && `pending_tiles`>0 && !`ld_bus_busy`.
  - Registered: `write_oa_granted`=1 for exactly one cycle.
  - `oa_bus_lock`=1.
  - `pending_tiles` decrements.
- **BUSY:** on `write_done`:
  - `tiles_written` increments and `oa_bus_lock` clears.
  - If the new `tiles_written` == latched `tile_count` → DONE, else → WAIT.
- **DONE:** `oa_calc_over`=1 and stays high until `init_cfg` or `rst`. `write_oa_req` is ignored.
- **Pending counter:**
  - Increments on `tile_ready` and decrements on grant; both in the same cycle → unchanged.
  - At MAX_PENDING, an incoming `tile_ready` is dropped, the counter saturates and `overflow_err` is set.
  - `tile_ready` is counted in every state except IDLE.
- **`ld_pause`** = (`pending_tiles` >= HIGH_WATER) || (state==WAIT && `write_oa_req` && `pending_tiles`>0 && `ld_bus_busy`).
  - It is combinational from registered state and inputs.
- **`init_cfg` mid-operation (WAIT/BUSY/DONE):** abort.
  - Relatch config and clear all counters and flags.
  - Drop `oa_bus_lock`; go to WAIT (or DONE if `tile_count`==0).
  - `init_cfg` has priority over every simultaneous event.
- **Width:** `tiles_written` compares against the full REG_WIDTH `tile_count`; no wrap is possible before DONE.
- **`write_done` in any state other than BUSY:** ignored except for setting `proto_err`.

## Timing
- **Reset values:** all outputs 0; state IDLE.
- **Grant latency:** conditions true in cycle N → `write_oa_granted` high in N+1, together with `oa_bus_lock` high and the state in BUSY.
- **No back-to-back grants:** minimum 1 cycle between a `write_done` pulse and the next grant, because WAIT is re-entered for at least one cycle.
- `oa_bus_lock` is high from the grant cycle through the `write_done` cycle inclusive, and low the cycle after.
- `oa_calc_over` rises the cycle after the final `write_done`.
- Counter updates are visible the cycle after the causing event.
- `ld_bus_busy` rising in the same cycle the grant is decided blocks the grant, since the decision uses the sampled value.

## Test plan
- **Basic flow:** `tile_count`=3; 3 `tile_ready` pulses; `oa_writer` model requests and finishes each tile → 3 grants, each 1 cycle after its request, with `tiles_written` reaching 3. `oa_calc_over` rises 1 cycle after the 3rd `write_done`.
- **Zero tiles:** `tile_count`=0 with `init_cfg` → DONE and `oa_calc_over`=1 next cycle, with no grants issued.
- **Bus contention:** `ld_bus_busy`=1 while a request is pending → no grant and `ld_pause`=1; `ld_bus_busy` drops at cycle N → grant at N+1.
- **Credits:** 5 `tile_ready` pulses with no grants, MAX_PENDING=4 → `pending_tiles`=4, `overflow_err`=1, and `ld_pause`=1 from `pending_tiles`=3 onward. `tile_ready` coincident with a grant leaves `pending_tiles` unchanged.
- **Abort:** `init_cfg` during BUSY with `tile_count`=2 → `oa_bus_lock` cleared, counters zeroed, state WAIT; a subsequent full 2-tile run completes normally.
- **Protocol error and reset:**
  - Stray `write_done` in WAIT → `proto_err`=1, with `tiles_written` unchanged.
  - `rst` asserted mid-BUSY → all outputs 0 the next cycle.
